// File: rtl/rf_bypass_param.sv
// Parametrised register file with two write ports, two combinational read ports,
// optional same-cycle write-to-read forwarding and a sticky illegal-access flag.
module rf_bypass_param #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int SELW    = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  input  logic [SELW-1:0]  writeregsel_a,
  input  logic [WIDTH-1:0] writedata_a,
  input  logic             write_a,
  input  logic [SELW-1:0]  writeregsel_b,
  input  logic [WIDTH-1:0] writedata_b,
  input  logic             write_b,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             err
);

  // One extra bit so DEPTH == 2**SELW still compares correctly.
  localparam logic [SELW:0] DEPTH_W = (SELW + 1)'(DEPTH);

  logic [WIDTH-1:0] regs_reg [DEPTH];
  logic             err_reg;
  logic             err_next;

  logic sel_a_ok, sel_b_ok, rd1_ok, rd2_ok;
  logic wr_a_legal, wr_b_legal;

  assign sel_a_ok = {1'b0, writeregsel_a} < DEPTH_W;
  assign sel_b_ok = {1'b0, writeregsel_b} < DEPTH_W;
  assign rd1_ok   = {1'b0, read1regsel} < DEPTH_W;
  assign rd2_ok   = {1'b0, read2regsel} < DEPTH_W;

  assign wr_a_legal = write_a && sel_a_ok && !((ZERO_R0 != 0) && (writeregsel_a == '0));
  assign wr_b_legal = write_b && sel_b_ok && !((ZERO_R0 != 0) && (writeregsel_b == '0));

  // Port B is tested first so it wins a same-register collision.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [SELW-1:0] IDX = SELW'(gi);
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (wr_b_legal && (writeregsel_b == IDX)) begin
          regs_reg[gi] <= writedata_b;
        end else if (wr_a_legal && (writeregsel_a == IDX)) begin
          regs_reg[gi] <= writedata_a;
        end
      end
    end
  endgenerate

  logic [SELW-1:0]  rd_sel  [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_sel[0] = read1regsel;
  assign rd_sel[1] = read2regsel;

  // An out-of-range select matches no entry and no legal write, so it reads 0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_sel[p] == SELW'(i)) begin
          rd_data[p] = regs_reg[i];
        end
      end
      if (BYPASS != 0) begin
        if (wr_a_legal && (writeregsel_a == rd_sel[p])) begin
          rd_data[p] = writedata_a;
        end
        if (wr_b_legal && (writeregsel_b == rd_sel[p])) begin
          rd_data[p] = writedata_b;
        end
      end
      if ((ZERO_R0 != 0) && (rd_sel[p] == '0)) begin
        rd_data[p] = '0;
      end
    end
  end

  assign read1data = rd_data[0];
  assign read2data = rd_data[1];

  always_comb begin
    err_next = err_reg;
    if ((write_a && !sel_a_ok) || (write_b && !sel_b_ok) || !rd1_ok || !rd2_ok ||
        (write_a && write_b && (writeregsel_a == writeregsel_b))) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;

endmodule

// File: tb/tb_rf_bypass_param.sv
// Bench for rf_bypass_param: four instances (default, no bypass, depth 6, zero r0)
// share one stimulus stream; expected outputs are queued when driven and checked at negedge.
module tb_rf_bypass_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  r1sel, r2sel, wsa, wsb;
  logic [15:0] wda, wdb;
  logic        wa, wb;
  logic [15:0] r1d [4];
  logic [15:0] r2d [4];
  logic        erro [4];

  always #5 clk = ~clk;

  rf_bypass_param #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(1), .ZERO_R0(0)) u_def (
    .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
    .writeregsel_a(wsa), .writedata_a(wda), .write_a(wa),
    .writeregsel_b(wsb), .writedata_b(wdb), .write_b(wb),
    .read1data(r1d[0]), .read2data(r2d[0]), .err(erro[0]));

  rf_bypass_param #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(0), .ZERO_R0(0)) u_nobyp (
    .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
    .writeregsel_a(wsa), .writedata_a(wda), .write_a(wa),
    .writeregsel_b(wsb), .writedata_b(wdb), .write_b(wb),
    .read1data(r1d[1]), .read2data(r2d[1]), .err(erro[1]));

  rf_bypass_param #(.WIDTH(16), .DEPTH(6), .SELW(3), .BYPASS(1), .ZERO_R0(0)) u_d6 (
    .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
    .writeregsel_a(wsa), .writedata_a(wda), .write_a(wa),
    .writeregsel_b(wsb), .writedata_b(wdb), .write_b(wb),
    .read1data(r1d[2]), .read2data(r2d[2]), .err(erro[2]));

  rf_bypass_param #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(1), .ZERO_R0(1)) u_z0 (
    .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
    .writeregsel_a(wsa), .writedata_a(wda), .write_a(wa),
    .writeregsel_b(wsb), .writedata_b(wdb), .write_b(wb),
    .read1data(r1d[3]), .read2data(r2d[3]), .err(erro[3]));

  typedef struct {
    logic        rst;
    logic [2:0]  r1, r2, sa;
    logic [15:0] da;
    logic        wa;
    logic [2:0]  sb;
    logic [15:0] db;
    logic        wb;
    logic [15:0] e1, e2;
    logic        ee;
  } vec_t;

  typedef struct {
    int          d;
    logic [15:0] e1, e2;
    logic        ee;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rs, logic [2:0] a1, logic [2:0] a2,
                              logic [2:0] sa, logic [15:0] da, logic ea,
                              logic [2:0] sb, logic [15:0] db, logic eb,
                              logic [15:0] e1, logic [15:0] e2, logic ee);
    vec_t v;
    v.rst = rs; v.r1 = a1; v.r2 = a2;
    v.sa = sa; v.da = da; v.wa = ea;
    v.sb = sb; v.db = db; v.wb = eb;
    v.e1 = e1; v.e2 = e2; v.ee = ee;
    return v;
  endfunction

  function automatic void push(int d, logic [15:0] e1, logic [15:0] e2, logic ee, string nm);
    exp_t x;
    x.d = d; x.e1 = e1; x.e2 = e2; x.ee = ee; x.nm = nm;
    sb_q.push_back(x);
  endfunction

  task automatic cmp(string nm, int d, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", nm, d, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; r1sel = v.r1; r2sel = v.r2;
    wsa = v.sa; wda = v.da; wa = v.wa;
    wsb = v.sb; wdb = v.db; wb = v.wb;
  endtask

  task automatic check_cycle();
    exp_t x;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      cmp({x.nm, " r1"}, x.d, r1d[x.d], x.e1);
      cmp({x.nm, " r2"}, x.d, r2d[x.d], x.e2);
      cmp({x.nm, " err"}, x.d, {15'd0, erro[x.d]}, {15'd0, x.ee});
      $display("txn %s dut%0d r1=%h r2=%h err=%b", x.nm, x.d, r1d[x.d], r2d[x.d], erro[x.d]);
    end
  endtask

  task automatic cyc(logic rs, logic [2:0] a1, logic [2:0] a2,
                     logic [2:0] sa, logic [15:0] da, logic ea,
                     logic [2:0] sb, logic [15:0] db, logic eb);
    drive(mk(rs, a1, a2, sa, da, ea, sb, db, eb, 16'h0, 16'h0, 1'b0));
  endtask

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; r1sel = '0; r2sel = '0; wsa = '0; wda = '0; wa = 1'b0;
    wsb = '0; wdb = '0; wb = 1'b0;

    //          rst r1 r2 sa da        wa sb db        wb exp1      exp2      err
    vecs[0]  = mk(1, 3, 1, 3, 16'hBEEF, 1, 0, 16'h0000, 0, 16'hBEEF, 16'h0000, 0);
    vecs[1]  = mk(0, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(0, 1, 2, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[3]  = mk(0, 4, 5, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[4]  = mk(0, 6, 7, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[5]  = mk(0, 2, 5, 2, 16'h1234, 1, 5, 16'hA5A5, 1, 16'h1234, 16'hA5A5, 0);
    vecs[6]  = mk(0, 2, 5, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 16'hA5A5, 0);
    vecs[7]  = mk(0, 4, 2, 4, 16'h00FF, 1, 0, 16'h0000, 0, 16'h00FF, 16'h1234, 0);
    vecs[8]  = mk(0, 4, 3, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h00FF, 16'h0000, 0);
    vecs[9]  = mk(0, 6, 4, 6, 16'h1111, 1, 6, 16'h2222, 1, 16'h2222, 16'h00FF, 0);
    vecs[10] = mk(0, 6, 6, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h2222, 16'h2222, 1);
    vecs[11] = mk(0, 1, 0, 1, 16'h0042, 1, 0, 16'h0000, 0, 16'h0042, 16'h0000, 1);
    vecs[12] = mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0042, 16'h0000, 1);
    vecs[13] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0042, 16'h0000, 1);
    vecs[14] = mk(0, 1, 6, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);

    @(posedge clk);
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      push(0, vecs[i].e1, vecs[i].e2, vecs[i].ee, $sformatf("vec%0d", i));
      check_cycle();
    end

    // No-bypass: same-cycle reads see pre-write contents; collision stores B and flags err.
    cyc(1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0); check_cycle();
    cyc(0, 4, 0, 4, 16'h0077, 1, 0, 16'h0, 0);
    push(1, 16'h0000, 16'h0, 0, "nb_pre"); push(0, 16'h0077, 16'h0, 0, "byp_pre"); check_cycle();
    cyc(0, 4, 0, 4, 16'h00FF, 1, 0, 16'h0, 0);
    push(1, 16'h0077, 16'h0, 0, "nb_same"); push(0, 16'h00FF, 16'h0, 0, "byp_same"); check_cycle();
    cyc(0, 4, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(1, 16'h00FF, 16'h0, 0, "nb_next"); check_cycle();
    cyc(0, 6, 6, 6, 16'h1111, 1, 6, 16'h2222, 1);
    push(1, 16'h0000, 16'h0000, 0, "nb_coll"); check_cycle();
    cyc(0, 6, 6, 0, 16'h0, 0, 0, 16'h0, 0);
    push(1, 16'h2222, 16'h2222, 1, "nb_coll_next"); check_cycle();

    // Depth 6: select 7 is out of range for writes and reads.
    cyc(1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0); check_cycle();
    cyc(0, 7, 5, 7, 16'hDEAD, 1, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 0, "d6_wr7"); push(0, 16'hDEAD, 16'h0, 0, "d8_wr7"); check_cycle();
    cyc(0, 7, 5, 0, 16'h0, 0, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 1, "d6_err"); push(0, 16'hDEAD, 16'h0, 0, "d8_keep7"); check_cycle();
    cyc(0, 1, 3, 0, 16'h0, 0, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 1, "d6_unchanged"); check_cycle();
    cyc(1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 1, "d6_err_in_rst"); check_cycle();
    cyc(0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 0, "d6_err_clr"); check_cycle();
    cyc(0, 6, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 0, "d6_rd6"); check_cycle();
    cyc(0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(2, 16'h0, 16'h0, 1, "d6_rderr"); check_cycle();

    // Zero r0: writes to reg 0 vanish and never bypass.
    cyc(1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0); check_cycle();
    cyc(0, 0, 0, 0, 16'hFFFF, 1, 0, 16'h0, 0);
    push(3, 16'h0, 16'h0, 0, "z0_same"); push(0, 16'hFFFF, 16'hFFFF, 0, "r0_byp"); check_cycle();
    cyc(0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(3, 16'h0, 16'h0, 0, "z0_next"); push(0, 16'hFFFF, 16'hFFFF, 0, "r0_kept"); check_cycle();
    cyc(0, 1, 0, 1, 16'h0123, 1, 0, 16'h0456, 1);
    push(3, 16'h0123, 16'h0, 0, "z0_dual"); push(0, 16'h0123, 16'h0456, 0, "r0_dual"); check_cycle();
    cyc(0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    push(3, 16'h0123, 16'h0, 0, "z0_dual_next"); push(0, 16'h0123, 16'h0456, 0, "r0_dual_next");
    check_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_bypass_param.md
Name: rf_bypass_param

Overview:
- Parametrised multi-write register file for the pipelined datapath. It supersedes the fixed 8x16, single-write-port file.
- Configurable data width and register count.
- Two write ports for a dual-issue writeback stage.
- Optional write-to-read bypass so the decode stage sees same-cycle writeback data without a hazard bubble.
- Registered error flag for illegal accesses.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 8, number of registers; 2..256, power of two not required.
- SELW, 3, select width; must satisfy 2^SELW >= DEPTH.
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs; 0 = reads return pre-write contents.
- ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- read1regsel  input  SELW  read port 1 select.
- read2regsel  input  SELW  read port 2 select.
- writeregsel_a  input  SELW  write port A select.
- writedata_a  input  WIDTH  write port A data.
- write_a  input  1  write port A enable.
- writeregsel_b  input  SELW  write port B select.
- writedata_b  input  WIDTH  write port B data.
- write_b  input  1  write port B enable.
- read1data  output  WIDTH  read port 1 data.
- read2data  output  WIDTH  read port 2 data.
- err  output  1  registered error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset: on a clk edge with rst=1, all DEPTH registers clear to 0 and err clears to 0.
  - Writes presented in a reset cycle are discarded.
  - Reads during reset are combinational from the current contents, with bypass still active.
  - From the cycle after reset, read outputs are 0.
- Write: with write_x=1 and a legal select, writedata_x is stored at the rising edge; it is visible on reads from the next cycle.
- Dual write, same register: port B wins and the register takes writedata_b.
- Dual write, different registers: both are written in the same cycle.
- Illegal write: select >= DEPTH, or select == 0 when ZERO_R0=1. The write is dropped and no register changes.
- Read: combinational, zero added latency.
  - Select >= DEPTH returns 0.
  - With ZERO_R0=1, select 0 always returns 0.
- Bypass (BYPASS=1): if a read select equals an enabled, legal write select in the same cycle, the output is that write's data.
  - If both write ports match, writedata_b is returned, consistent with port B priority.
  - Bypass is suppressed for dropped writes and for register 0 when ZERO_R0=1.
- BYPASS=0: reads always return the stored value.
- err: registered, sticky until reset.
  - It is set at the clk edge after any cycle containing an enabled out-of-range write select, an out-of-range read select, or an enabled dual write to the same register.
  - rst=1 clears err and takes priority over setting it in the same cycle.
  - A read-select error is flagged regardless of write activity.
- Registers hold their values whenever write enables are low; there is no other state.
- Implementation: register array plus per-port compare/mux logic. Equivalent behavioural or structural coding is acceptable.

Test Plan:
- Reset and read-back: assert rst for 1 cycle with write_a=1 to reg 3, value 16'hBEEF; then read all regs -> every read returns 16'h0000, err=0.
- Basic write/read: write_a reg 2 = 16'h1234, write_b reg 5 = 16'hA5A5 in one cycle; next cycle read1=2, read2=5 -> 16'h1234 and 16'hA5A5, err=0.
- Bypass: BYPASS=1; write_a reg 4 = 16'h00FF with read1regsel=4 in the same cycle -> read1data=16'h00FF that cycle. Rerun with BYPASS=0 -> previous reg 4 contents that cycle, 16'h00FF next cycle.
- Write collision: write_a and write_b both to reg 6, data 16'h1111 and 16'h2222, bypass read of reg 6 -> read shows 16'h2222 same cycle; reg 6 = 16'h2222 after the edge; err=1 from the next cycle and stays 1 until rst.
- Non-power-of-two depth: DEPTH=6, SELW=3; write_a reg 7 = 16'hDEAD -> no register changes, read of 7 returns 0, err=1 next cycle. rst clears err.
- ZERO_R0=1: write_a reg 0 = 16'hFFFF with read1regsel=0 -> read1data=0 that cycle and the next; err stays 0.
